// File: rtl/periph_access_seq_if.sv
// Bundles the MEM-stage request side and the peripheral handshake side of the
// access sequencer; the sequencer takes the slave view, the stage/peripheral models take master.
interface periph_access_seq_if #(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 3
);
  logic              REQ_VALID;
  logic              REQ_SEL;
  logic              REQ_WE;
  logic [CTRL_W-1:0] REQ_CTRL;
  logic [DATA_W-1:0] REQ_ADDR;
  logic [DATA_W-1:0] REQ_WDATA;
  logic              PERIPH_ACK;
  logic [DATA_W-1:0] PERIPH_RDATA;
  logic              PERIPH_REQ;
  logic              PERIPH_WE;
  logic [CTRL_W-1:0] PERIPH_CTRL;
  logic [DATA_W-1:0] PERIPH_ADDR;
  logic [DATA_W-1:0] PERIPH_WDATA;
  logic              STALL;
  logic [DATA_W-1:0] RDATA;
  logic              RDATA_VALID;
  logic              TIMEOUT_ERR;

  modport slave (
    input  REQ_VALID, REQ_SEL, REQ_WE, REQ_CTRL, REQ_ADDR, REQ_WDATA,
    input  PERIPH_ACK, PERIPH_RDATA,
    output PERIPH_REQ, PERIPH_WE, PERIPH_CTRL, PERIPH_ADDR, PERIPH_WDATA,
    output STALL, RDATA, RDATA_VALID, TIMEOUT_ERR
  );

  modport master (
    output REQ_VALID, REQ_SEL, REQ_WE, REQ_CTRL, REQ_ADDR, REQ_WDATA,
    output PERIPH_ACK, PERIPH_RDATA,
    input  PERIPH_REQ, PERIPH_WE, PERIPH_CTRL, PERIPH_ADDR, PERIPH_WDATA,
    input  STALL, RDATA, RDATA_VALID, TIMEOUT_ERR
  );
endinterface

// File: rtl/periph_access_seq.sv
// MEM-stage access sequencer: RAM accesses pass through, peripheral accesses run a
// REQ/ACK handshake under STALL, with a timeout that returns ERR_VALUE and sets a sticky flag.
module periph_access_seq #(
  parameter int                 DATA_W         = 48,
  parameter int                 CTRL_W         = 3,
  parameter int                 TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0]  ERR_VALUE      = {DATA_W{1'b1}}
) (
  input  logic                 CLK,
  input  logic                 Reset,
  periph_access_seq_if.slave   bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_req;
  logic                r_we;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                w_start;
  logic                w_timeout;
  logic                w_stall;

  assign w_start   = bus.REQ_VALID & ~bus.REQ_SEL;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next  = S_ISSUE;
          w_stall = 1'b1;
        end
      end
      S_ISSUE: begin
        w_stall = 1'b1;
        // A lingering ACK from the previous access must clear before a new REQ.
        if (!bus.PERIPH_ACK) w_next = S_WAIT;
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (bus.PERIPH_ACK || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_ctrl  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_we    <= bus.REQ_WE;
            r_ctrl  <= bus.REQ_CTRL;
            r_addr  <= bus.REQ_ADDR;
            r_wdata <= bus.REQ_WDATA;
          end
        end
        S_ISSUE: begin
          if (!bus.PERIPH_ACK) begin
            r_req <= 1'b1;
            r_cnt <= '0;
          end
        end
        S_WAIT: begin
          // ACK takes priority over a timeout landing in the same cycle.
          if (bus.PERIPH_ACK) begin
            r_rdata <= bus.PERIPH_RDATA;
            r_req   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= ERR_VALUE;
            r_err   <= 1'b1;
            r_req   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PERIPH_REQ   = r_req;
  assign bus.PERIPH_WE    = r_we;
  assign bus.PERIPH_CTRL  = r_ctrl;
  assign bus.PERIPH_ADDR  = r_addr;
  assign bus.PERIPH_WDATA = r_wdata;
  assign bus.STALL        = w_stall & ~Reset;
  assign bus.RDATA        = r_rdata;
  assign bus.RDATA_VALID  = (r_state == S_DONE) & ~Reset;
  assign bus.TIMEOUT_ERR  = r_err;

endmodule
